// File: rtl/alu32_sequencer.sv
// Register-file command sequencer driving a registered ALU (a/b/sel out, result/overflow in).
// Optional macro ALU_SEQ_OVF_TRAP_EN: ADD/SUB overflow suppresses writeback and stalls until ovf_clr.
module alu32_sequencer #(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              done,
    output logic [REG_AW-1:0] done_rd,
    output logic              err,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int NREG  = 2**REG_AW;
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_LOADI = 4'b1000;

    typedef enum logic [1:0] {IDLE, WAIT, WB, TRAP} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [REG_AW-1:0]   rd_reg;
    logic [3:0]          op_reg;
    logic [DATA_W-1:0]   rf [NREG];

    logic                accept;
    logic                is_alu_op;
    logic                is_loadi;
    logic                wb_ovf;
    logic                wr_en;
    logic [REG_AW-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic                done_next;
    logic                err_next;
    logic [REG_AW-1:0]   done_rd_next;

    assign cmd_ready = (state_reg == IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign is_alu_op = (cmd_op <= OP_SUB);
    assign is_loadi  = (cmd_op == OP_LOADI);
    // Overflow only means something for the arithmetic ops; logic ops ignore the flag.
    assign wb_ovf    = (state_reg == WB) && ((op_reg == OP_ADD) || (op_reg == OP_SUB))
                       && alu_overflow;
    assign dbg_data  = rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        wr_en        = 1'b0;
        wr_addr      = rd_reg;
        wr_data      = alu_out;
        done_next    = 1'b0;
        err_next     = 1'b0;
        done_rd_next = rd_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    done_rd_next = cmd_rd;
                    if (is_alu_op) begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(ALU_LAT);
                    end else if (is_loadi) begin
                        wr_en     = 1'b1;
                        wr_addr   = cmd_rd;
                        wr_data   = cmd_imm;
                        done_next = 1'b1;
                    end else begin
                        done_next = 1'b1;
                        err_next  = 1'b1;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = WB;
                end
            end
            WB: begin
                done_next  = 1'b1;
                state_next = IDLE;
`ifdef ALU_SEQ_OVF_TRAP_EN
                if (wb_ovf) begin
                    state_next = TRAP;
                end else begin
                    wr_en = 1'b1;
                end
`else
                wr_en = 1'b1;
`endif
            end
            TRAP: begin
`ifdef ALU_SEQ_OVF_TRAP_EN
                if (ovf_clr) begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are captured at accept so rd may alias rs1/rs2 safely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= 4'b0000;
            rd_reg  <= '0;
            op_reg  <= 4'b0000;
        end else if (accept && is_alu_op) begin
            alu_a   <= rf[cmd_rs1];
            alu_b   <= rf[cmd_rs2];
            alu_sel <= cmd_op;
            rd_reg  <= cmd_rd;
            op_reg  <= cmd_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done       <= 1'b0;
            err        <= 1'b0;
            done_rd    <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            done <= done_next;
            err  <= err_next;
            if (done_next) begin
                done_rd <= done_rd_next;
            end
            // A new overflow in the same cycle as a clear keeps the flag set.
            if (wb_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

endmodule
